// File: rtl/pw_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pw_fifo_pkg
// Description : Shared sniff-FIFO entry layout for the PhyWhisperer-USB
//               front end, register block and benches.
// Revision    : 1.0 - initial release
// ============================================================================
package pw_fifo_pkg;

  // Entry command encodings, bits [17:16] of every entry
  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'b00;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'b01;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b10;

  // Entry width and field start/length positions
  localparam int FE_FIFO_W              = 18;
  localparam int FE_FIFO_CMD_START      = 16;
  localparam int FE_FIFO_CMD_LEN        = 2;
  localparam int FE_FIFO_DATA_START     = 8;
  localparam int FE_FIFO_DATA_LEN       = 8;
  localparam int FE_FIFO_STAT_START     = 3;
  localparam int FE_FIFO_STAT_LEN       = 5;
  localparam int FE_FIFO_SHORT_TIME_START = 0;
  localparam int FE_FIFO_SHORT_TIME_LEN   = 3;
  localparam int FE_FIFO_FULL_TIME_START  = 0;
  localparam int FE_FIFO_FULL_TIME_LEN    = 16;

  // Bit positions of the PHY status inside stat[4:0], LSB first
  localparam int FE_STAT_W         = 5;
  localparam int FE_STAT_RXACTIVE  = 0;
  localparam int FE_STAT_RXERROR   = 1;
  localparam int FE_STAT_SESSVLD   = 2;
  localparam int FE_STAT_SESSEND   = 3;
  localparam int FE_STAT_VBUSVLD   = 4;

  // Capture control states: PRIME is the single edge that loads the first
  // sample into the stage before any emit decision is taken.
  typedef enum logic [1:0] {
    FE_CAP_IDLE  = 2'd0,
    FE_CAP_PRIME = 2'd1,
    FE_CAP_RUN   = 2'd2
  } fe_cap_state_e;

endpackage : pw_fifo_pkg
`default_nettype wire

// File: rtl/fe_event_packer.sv
`default_nettype none
// ============================================================================
// Module      : fe_event_packer
// Description : Samples UTMI receive signals and encodes each byte or status
//               change as an 18-bit sniff-FIFO entry with a relative
//               timestamp; long idle gaps are carried by TIME entries.
// Revision    : 1.0 - initial release
// ============================================================================
module fe_event_packer
  import pw_fifo_pkg::*;
#(
  parameter int pSHORT_TIME_W = 3,
  parameter int pFULL_TIME_W  = 16
) (
  input  logic                 fe_clk,
  input  logic                 reset_n,
  input  logic [7:0]           fe_data,
  input  logic                 fe_rxvalid,
  input  logic                 fe_rxactive,
  input  logic                 fe_rxerror,
  input  logic                 fe_sessvld,
  input  logic                 fe_sessend,
  input  logic                 fe_vbusvld,
  input  logic                 capture_en,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [FE_FIFO_W-1:0] fifo_din,
  output logic                 capturing,
  output logic                 overflow
);

  // Largest idle count that still fits the short time field
  localparam logic [pFULL_TIME_W-1:0] c_short_max =
    pFULL_TIME_W'((1 << pSHORT_TIME_W) - 1);
  // Idle counter saturation point
  localparam logic [pFULL_TIME_W-1:0] c_full_max = '1;

  fe_cap_state_e r_state;
  fe_cap_state_e w_state_nxt;

  // Sample stage
  logic [7:0]              s_data;
  logic                    s_rxvalid;
  logic [FE_STAT_W-1:0]    s_stat;
  logic                    s_event;

  logic [pFULL_TIME_W-1:0] cnt;
  logic [pFULL_TIME_W-1:0] w_cnt_inc;
  logic [pFULL_TIME_W-1:0] w_cnt_nxt;
  logic                    r_capture_en_d;

  logic [FE_STAT_W-1:0]    w_stat_in;
  logic                    w_ev_next;
  logic                    w_run;
  logic                    w_sample;
  logic                    w_want_wr;
  logic                    w_drop;
  logic                    w_arm_rise;
  logic [FE_FIFO_W-1:0]    w_entry;

  assign w_stat_in  = {fe_vbusvld, fe_sessend, fe_sessvld, fe_rxerror, fe_rxactive};
  // Live inputs act as a one-cycle lookahead against the previous sample
  assign w_ev_next  = fe_rxvalid | (w_stat_in != s_stat);
  assign w_cnt_inc  = cnt + pFULL_TIME_W'(1);
  assign w_run      = (r_state == FE_CAP_RUN) & capture_en;
  assign w_drop     = w_want_wr & fifo_full;
  assign w_sample   = (r_state != FE_CAP_IDLE) & capture_en & ~w_drop;
  assign w_arm_rise = capture_en & ~r_capture_en_d;
  assign capturing  = (r_state != FE_CAP_IDLE);

  // Capture state register
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FE_CAP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arm / prime / disarm transitions; overflow blocks arming until re-armed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FE_CAP_IDLE: begin
        if (capture_en && !overflow) begin
          w_state_nxt = FE_CAP_PRIME;
        end
      end
      FE_CAP_PRIME: begin
        w_state_nxt = capture_en ? FE_CAP_RUN : FE_CAP_IDLE;
      end
      FE_CAP_RUN: begin
        if (!capture_en || w_drop) begin
          w_state_nxt = FE_CAP_IDLE;
        end
      end
      default: begin
        w_state_nxt = FE_CAP_IDLE;
      end
    endcase
  end

  // Per-edge emit decision in priority order: DATA, STAT, lookahead TIME
  // flush, saturation TIME, otherwise count one more idle cycle.
  always_comb begin
    w_want_wr = 1'b0;
    w_entry   = '0;
    w_cnt_nxt = cnt;
    if (w_run) begin
      if (s_event && s_rxvalid) begin
        w_want_wr = 1'b1;
        w_entry   = {FE_FIFO_CMD_DATA, s_data, s_stat, cnt[pSHORT_TIME_W-1:0]};
        w_cnt_nxt = '0;
      end else if (s_event) begin
        w_want_wr = 1'b1;
        w_entry   = {FE_FIFO_CMD_STAT, 8'h00, s_stat, cnt[pSHORT_TIME_W-1:0]};
        w_cnt_nxt = '0;
      end else if (w_ev_next && (w_cnt_inc > c_short_max)) begin
        // Flush the gap now so the upcoming event carries short time 0
        w_want_wr = 1'b1;
        w_entry   = {FE_FIFO_CMD_TIME, w_cnt_inc};
        w_cnt_nxt = '0;
      end else if (w_cnt_inc == c_full_max) begin
        w_want_wr = 1'b1;
        w_entry   = {FE_FIFO_CMD_TIME, c_full_max};
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  // Overflow is sticky until a fresh capture_en rising edge
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_capture_en_d <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      r_capture_en_d <= capture_en;
      if (w_arm_rise) begin
        overflow <= 1'b0;
      end else if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Sample stage: loads live inputs while capturing, held at zero otherwise
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      s_data    <= '0;
      s_rxvalid <= 1'b0;
      s_stat    <= '0;
      s_event   <= 1'b0;
    end else if (w_sample) begin
      s_data    <= fe_data;
      s_rxvalid <= fe_rxvalid;
      s_stat    <= w_stat_in;
      s_event   <= w_ev_next;
    end else begin
      s_data    <= '0;
      s_rxvalid <= 1'b0;
      s_stat    <= '0;
      s_event   <= 1'b0;
    end
  end

  // Idle counter: only advances on emit decisions, cleared whenever idle
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (w_run) begin
      cnt <= w_cnt_nxt;
    end else begin
      cnt <= '0;
    end
  end

  // Output register: a full FIFO drops the entry instead of writing it
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      fifo_wr_en <= w_want_wr & ~fifo_full;
      if (w_want_wr && !fifo_full) begin
        fifo_din <= w_entry;
      end
    end
  end

  // DATA/STAT entries must never need more than the short time field
  a_short_time_fits : assert property (
    @(posedge fe_clk) disable iff (!reset_n)
    (w_run && s_event) |-> (cnt <= c_short_max)
  );

endmodule : fe_event_packer
`default_nettype wire

// File: tb/tb_fe_event_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fe_event_packer
// Description : Scoreboard bench for fe_event_packer: expected entries are
//               queued as stimulus is driven and compared on each write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fe_event_packer;

  logic        fe_clk = 1'b0;
  logic        reset_n;
  logic [7:0]  fe_data;
  logic        fe_rxvalid;
  logic        fe_rxactive, fe_rxerror, fe_sessvld, fe_sessend, fe_vbusvld;
  logic        capture_en;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [17:0] fifo_din;
  logic        capturing;
  logic        overflow;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          sb_en    = 1'b0;
  logic [17:0] exp_q[$];

  fe_event_packer dut (
    .fe_clk      (fe_clk),
    .reset_n     (reset_n),
    .fe_data     (fe_data),
    .fe_rxvalid  (fe_rxvalid),
    .fe_rxactive (fe_rxactive),
    .fe_rxerror  (fe_rxerror),
    .fe_sessvld  (fe_sessvld),
    .fe_sessend  (fe_sessend),
    .fe_vbusvld  (fe_vbusvld),
    .capture_en  (capture_en),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .capturing   (capturing),
    .overflow    (overflow)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge fe_clk);
  endtask

  task automatic set_stat(input logic [4:0] s);
    {fe_vbusvld, fe_sessend, fe_sessvld, fe_rxerror, fe_rxactive} = s;
  endtask

  task automatic push_data(input logic [7:0] d, input logic [4:0] s, input logic [2:0] t);
    exp_q.push_back({2'b00, d, s, t});
  endtask

  task automatic push_stat(input logic [4:0] s, input logic [2:0] t);
    exp_q.push_back({2'b01, 8'h00, s, t});
  endtask

  task automatic push_time(input logic [15:0] t);
    exp_q.push_back({2'b10, t});
  endtask

  // Raise capture_en and wait (bounded) for capturing
  task automatic arm(input string tag);
    capture_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (capturing) break;
    end
    chk({tag, "_arm"}, 32'(capturing), 32'd1);
  endtask

  task automatic disarm(input string tag);
    fe_rxvalid = 1'b0;
    tick(4);
    capture_en = 1'b0;
    tick(2);
    fe_data = 8'h00;
    set_stat(5'h00);
    tick(2);
    chk({tag, "_disarm"}, 32'(capturing), 32'd0);
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every write must match the head of the expected queue
  always @(negedge fe_clk) begin
    logic [17:0] exp;
    if (sb_en && fifo_wr_en) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
      chk("entry", 32'(fifo_din), 32'(exp));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    fe_data    = 8'h00;
    fe_rxvalid = 1'b0;
    set_stat(5'h00);
    capture_en = 1'b0;
    fifo_full  = 1'b0;
    tick(3);
    chk("rst_wr_en",     32'(fifo_wr_en), 32'd0);
    chk("rst_din",       32'(fifo_din),   32'd0);
    chk("rst_capturing", 32'(capturing),  32'd0);
    chk("rst_overflow",  32'(overflow),   32'd0);
    reset_n = 1'b1;
    tick(2);
    sb_en = 1'b1;

    // Back-to-back DATA with constant stat 0x05
    arm("b2b");
    set_stat(5'h05);
    fe_rxvalid = 1'b1;
    foreach (exp_q[i]) begin end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = 8'h11 * 8'(i + 1);
      fe_data = b;
      push_data(b, 5'h05, 3'd0);
      tick();
    end
    disarm("b2b");

    // Status changes without data
    arm("stat");
    set_stat(5'h0A);
    push_stat(5'h0A, 3'd0);
    tick();
    tick(3);
    set_stat(5'h1F);
    push_stat(5'h1F, 3'd3);
    tick();
    disarm("stat");

    // Long gap: 20 idle cycles between two bytes
    arm("gap");
    fe_data = 8'hA5; fe_rxvalid = 1'b1;
    push_data(8'hA5, 5'h00, 3'd0);
    tick();
    fe_rxvalid = 1'b0;
    tick(20);
    push_time(16'd20);
    fe_data = 8'h5A; fe_rxvalid = 1'b1;
    push_data(8'h5A, 5'h00, 3'd0);
    tick();
    disarm("gap");

    // Saturation: 70000 idle cycles then one byte
    arm("sat");
    push_time(16'hFFFF);
    tick(70000);
    push_time(16'd4465);
    fe_data = 8'h01; fe_rxvalid = 1'b1;
    push_data(8'h01, 5'h00, 3'd0);
    tick();
    disarm("sat");

    // Overflow: event while FIFO full is dropped and stops capture
    arm("ovf");
    fifo_full = 1'b1;
    fe_data = 8'h77; fe_rxvalid = 1'b1;
    tick();
    fe_rxvalid = 1'b0;
    tick(3);
    chk("ovf_flag",      32'(overflow),  32'd1);
    chk("ovf_capturing", 32'(capturing), 32'd0);
    fe_data = 8'h88; fe_rxvalid = 1'b1;
    tick();
    fe_rxvalid = 1'b0;
    fifo_full = 1'b0;
    tick(3);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    capture_en = 1'b0;
    tick(2);
    arm("rearm");
    chk("rearm_ovf_clr", 32'(overflow), 32'd0);
    fe_data = 8'h99; fe_rxvalid = 1'b1;
    push_data(8'h99, 5'h00, 3'd0);
    tick();
    disarm("rearm");

    // Asynchronous reset in the middle of a burst
    sb_en = 1'b0;
    arm("rst");
    fe_rxvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fe_data = 8'(8'hC0 + i);
      tick();
    end
    chk("rst_burst_wr", 32'(fifo_wr_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_wr_en",     32'(fifo_wr_en), 32'd0);
    chk("mid_rst_din",       32'(fifo_din),   32'd0);
    chk("mid_rst_capturing", 32'(capturing),  32'd0);
    chk("mid_rst_overflow",  32'(overflow),   32'd0);
    capture_en = 1'b0;
    tick(2);
    reset_n = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;
    tick(5);
    chk("post_rst_idle", 32'(capturing), 32'd0);
    fe_rxvalid = 1'b0;
    tick();
    arm("post_rst");
    fe_data = 8'h42; fe_rxvalid = 1'b1;
    push_data(8'h42, 5'h00, 3'd0);
    tick();
    disarm("post_rst");

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fe_event_packer
`default_nettype wire
